// File: rtl/mx_mac_pkg.sv
// Shared types and constants for the MX MAC processing-element control path.
package mx_mac_pkg;

    // Sequencer states for one PE job.
    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StAccum,
        StDrain,
        StOut
    } mac_ctrl_state_e;

    // Element precision selected per job.
    typedef enum logic [1:0] {
        PREC_8B = 2'd0,
        PREC_4B = 2'd1,
        PREC_2B = 2'd2
    } prec_mode_e;

    // Element FP format encodings carried on FP_mode.
    localparam logic [1:0] FpE4M3 = 2'd0;
    localparam logic [1:0] FpE5M2 = 2'd1;
    localparam logic [1:0] FpE3M2 = 2'd2;
    localparam logic [1:0] FpE2M3 = 2'd3;

    // Accumulator exponent width; the mantissa width is set by the instantiating module.
    localparam int unsigned MacExpW = 8;

endpackage

// File: rtl/mx_mac_ctrl_perf.sv
// Saturating performance counters for the MAC sequencer: ACCUM stall cycles and finished jobs.
module mx_mac_ctrl_perf (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        job_i,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] job_cnt_o
);

    logic [31:0] stall_q, stall_d;
    logic [31:0] job_q, job_d;

    // Increment on event, hold at all-ones instead of wrapping.
    always_comb begin
        stall_d = stall_q;
        job_d   = job_q;
        if (stall_i && (stall_q != '1)) stall_d = stall_q + 32'd1;
        if (job_i && (job_q != '1))     job_d   = job_q + 32'd1;
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
            job_q   <= '0;
        end else begin
            stall_q <= stall_d;
            job_q   <= job_d;
        end
    end

    assign stall_cnt_o = stall_q;
    assign job_cnt_o   = job_q;

endmodule

// File: rtl/mx_mac_ctrl.sv
// Sequencer for one MX MAC processing element: clears the accumulator, gates paired A/B beats
// into the MAC for k_steps reductions, then captures and presents the result.
// Optional build macro: MX_MAC_CTRL_PERF_CNT_EN adds stall_cnt_o / job_cnt_o counters.
module mx_mac_ctrl
    import mx_mac_pkg::*;
#(
    parameter int unsigned K_W         = 8,
    parameter int unsigned M_out_width = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [K_W-1:0]         k_steps_i,
    input  logic [1:0]             prec_mode_i,
    input  logic [1:0]             FP_mode_i,
    output logic                   busy_o,
    output logic                   done_o,
    input  logic                   a_valid_i,
    output logic                   a_ready_o,
    input  logic                   b_valid_i,
    output logic                   b_ready_o,
    output logic                   mac_a_valid_o,
    output logic                   mac_b_valid_o,
    output logic                   mac_clear_o,
    output logic [1:0]             prec_mode_o,
    output logic [1:0]             FP_mode_o,
    input  logic [M_out_width-1:0] mac_mant_i,
    input  logic [MacExpW-1:0]     mac_exp_i,
    input  logic                   mac_sign_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [M_out_width-1:0] res_mant_o,
    output logic [MacExpW-1:0]     res_exp_o,
    output logic                   res_sign_o
`ifdef MX_MAC_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]            stall_cnt_o,
    output logic [31:0]            job_cnt_o
`endif
);

    // Result record; mantissa width follows the attached MAC.
    typedef struct packed {
        logic                   sign;
        logic [MacExpW-1:0]     exp;
        logic [M_out_width-1:0] mant;
    } mac_res_t;

    mac_ctrl_state_e state_q, state_d;
    logic [K_W-1:0]  k_q;
    logic [K_W-1:0]  cnt_q;
    prec_mode_e      prec_q;
    logic [1:0]      fp_q;
    mac_res_t        res_q;
    logic            done_q;

    logic in_accum;
    logic fire;
    logic last_beat;
    logic start_ok;

    // Outputs are forced inactive while reset is held, even before the reset edge lands.
    assign in_accum  = (state_q == StAccum) && !rst_i;
    assign fire      = in_accum && a_valid_i && b_valid_i;
    assign last_beat = (cnt_q == (k_q - K_W'(1)));
    assign start_ok  = (state_q == StIdle) && start_i && (k_steps_i != '0);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_ok) state_d = StClear;
            StClear: state_d = StAccum;
            StAccum: if (fire && last_beat) state_d = StDrain;
            StDrain: state_d = StOut;
            StOut:   if (res_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Job parameters, step counter, captured result and done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            k_q    <= '0;
            cnt_q  <= '0;
            prec_q <= PREC_8B;
            fp_q   <= '0;
            res_q  <= '0;
            done_q <= 1'b0;
        end else begin
            if (start_ok) begin
                k_q    <= k_steps_i;
                prec_q <= prec_mode_e'(prec_mode_i);
                fp_q   <= FP_mode_i;
            end
            if (state_q == StClear) begin
                cnt_q <= '0;
            end else if (fire && !last_beat) begin
                // The last beat leaves the counter at k-1 so it can never wrap.
                cnt_q <= cnt_q + K_W'(1);
            end
            if (state_q == StDrain) begin
                res_q <= '{sign: mac_sign_i, exp: mac_exp_i, mant: mac_mant_i};
            end
            done_q <= (state_q == StOut) && res_ready_i;
        end
    end

    assign a_ready_o     = in_accum && b_valid_i;
    assign b_ready_o     = in_accum && a_valid_i;
    assign mac_a_valid_o = fire;
    assign mac_b_valid_o = fire;
    assign mac_clear_o   = rst_i || (state_q == StClear);
    assign busy_o        = (state_q != StIdle) && !rst_i;
    assign res_valid_o   = (state_q == StOut) && !rst_i;
    assign done_o        = done_q && !rst_i;
    assign prec_mode_o   = prec_q;
    assign FP_mode_o     = fp_q;
    assign res_mant_o    = res_q.mant;
    assign res_exp_o     = res_q.exp;
    assign res_sign_o    = res_q.sign;

`ifdef MX_MAC_CTRL_PERF_CNT_EN
    mx_mac_ctrl_perf u_perf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .stall_i     (in_accum && !fire),
        .job_i       ((state_q == StOut) && res_ready_i && !rst_i),
        .stall_cnt_o (stall_cnt_o),
        .job_cnt_o   (job_cnt_o)
    );
`endif

endmodule

// File: tb/tb_mx_mac_ctrl.sv
// Self-checking bench for mx_mac_ctrl: a cycle table for a k=4 job plus directed sequences
// for stalls, k=0, result backpressure, mid-job reset and the maximum job length.
module tb_mx_mac_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  k_steps_i;
    logic [1:0]  prec_mode_i;
    logic [1:0]  FP_mode_i;
    logic        busy_o, done_o;
    logic        a_valid_i, a_ready_o, b_valid_i, b_ready_o;
    logic        mac_a_valid_o, mac_b_valid_o, mac_clear_o;
    logic [1:0]  prec_mode_o, FP_mode_o;
    logic [15:0] mac_mant_i;
    logic [7:0]  mac_exp_i;
    logic        mac_sign_i;
    logic        res_valid_o, res_ready_i;
    logic [15:0] res_mant_o;
    logic [7:0]  res_exp_o;
    logic        res_sign_o;
`ifdef MX_MAC_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_o, job_cnt_o;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    mx_mac_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .k_steps_i     (k_steps_i),
        .prec_mode_i   (prec_mode_i),
        .FP_mode_i     (FP_mode_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .a_valid_i     (a_valid_i),
        .a_ready_o     (a_ready_o),
        .b_valid_i     (b_valid_i),
        .b_ready_o     (b_ready_o),
        .mac_a_valid_o (mac_a_valid_o),
        .mac_b_valid_o (mac_b_valid_o),
        .mac_clear_o   (mac_clear_o),
        .prec_mode_o   (prec_mode_o),
        .FP_mode_o     (FP_mode_o),
        .mac_mant_i    (mac_mant_i),
        .mac_exp_i     (mac_exp_i),
        .mac_sign_i    (mac_sign_i),
        .res_valid_o   (res_valid_o),
        .res_ready_i   (res_ready_i),
        .res_mant_o    (res_mant_o),
        .res_exp_o     (res_exp_o),
        .res_sign_o    (res_sign_o)
`ifdef MX_MAC_CTRL_PERF_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt_o),
        .job_cnt_o     (job_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // One cycle record: inputs applied, then packed expected outputs.
    // exp_out = {busy, clear, a_rdy, b_rdy, mac_a_v, mac_b_v, res_v, done, prec[1:0], fp[1:0]}
    typedef struct {
        logic        start;
        logic [7:0]  k;
        logic        av;
        logic        bv;
        logic        rr;
        logic [1:0]  prec;
        logic [1:0]  fp;
        logic [11:0] exp_out;
        logic [24:0] exp_res;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic drive_mac(input logic [15:0] mbase, input logic [7:0] ebase, input int cyc);
        mac_mant_i = mbase + 16'(cyc);
        mac_exp_i  = ebase + 8'(cyc);
        mac_sign_i = cyc[0];
    endtask

    task automatic idle_inputs();
        start_i     = 1'b0;
        k_steps_i   = 8'd0;
        a_valid_i   = 1'b0;
        b_valid_i   = 1'b0;
        res_ready_i = 1'b0;
        prec_mode_i = 2'd0;
        FP_mode_i   = 2'd0;
    endtask

    // Hard stop if something hangs despite the bounded loops.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fires, bad, rv_cyc, rv_cnt, done_cnt, done_cyc, stable_bad, any_act;
        logic [24:0] rv_val;

        // k=4 job, both streams always valid, immediate result ready.
        vecs[0]  = '{1'b1, 8'd4, 1'b1, 1'b1, 1'b1, 2'd2, 2'd1, 12'h000, 25'd0};
        vecs[1]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd3, 12'hC09, 25'd0};
        vecs[2]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd3, 12'hBC9, 25'd0};
        vecs[3]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd3, 12'hBC9, 25'd0};
        vecs[4]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd3, 12'hBC9, 25'd0};
        vecs[5]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd3, 12'hBC9, 25'd0};
        vecs[6]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd3, 12'h809, 25'd0};
        vecs[7]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd3, 12'h829,
                     {1'b0, 8'h46, 16'h1006}};
        vecs[8]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd3, 12'h019, 25'd0};
        vecs[9]  = '{1'b1, 8'd0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd3, 12'h009, 25'd0};
        vecs[10] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd3, 12'h009, 25'd0};

        // Reset state.
        idle_inputs();
        drive_mac(16'h0, 8'h0, 0);
        rst_i = 1'b1;
        tick();
        tick();
        #1;
        check("reset_outputs",
              {busy_o, mac_clear_o, a_ready_o, b_ready_o, mac_a_valid_o, res_valid_o, done_o,
               prec_mode_o, FP_mode_o, res_mant_o, res_exp_o, res_sign_o},
              {1'b0, 1'b1, 5'b0, 4'b0, 25'b0});
        rst_i = 1'b0;
        tick();
        #1;
        check("idle_after_reset", {busy_o, mac_clear_o, res_valid_o, done_o}, 4'b0000);
        tick();

        // Cycle table.
        for (int i = 0; i < 11; i++) begin
            start_i     = vecs[i].start;
            k_steps_i   = vecs[i].k;
            a_valid_i   = vecs[i].av;
            b_valid_i   = vecs[i].bv;
            res_ready_i = vecs[i].rr;
            prec_mode_i = vecs[i].prec;
            FP_mode_i   = vecs[i].fp;
            drive_mac(16'h1000, 8'h40, i);
            #1;
            check($sformatf("k4_cycle%0d", i),
                  {busy_o, mac_clear_o, a_ready_o, b_ready_o, mac_a_valid_o, mac_b_valid_o,
                   res_valid_o, done_o, prec_mode_o, FP_mode_o},
                  vecs[i].exp_out);
            if (vecs[i].exp_out[5]) begin
                check($sformatf("k4_result_cycle%0d", i),
                      {res_sign_o, res_exp_o, res_mant_o}, vecs[i].exp_res);
            end
            tick();
        end

        // k=3, A always valid, B valid only on odd cycles.
        fires = 0; bad = 0; rv_cyc = -1;
        for (int cyc = 0; cyc < 21; cyc++) begin
            start_i     = (cyc == 0);
            k_steps_i   = 8'd3;
            a_valid_i   = 1'b1;
            b_valid_i   = cyc[0];
            res_ready_i = 1'b1;
            drive_mac(16'h0, 8'h0, cyc);
            #1;
            if (mac_a_valid_o) fires++;
            if ((mac_a_valid_o || mac_b_valid_o) && !b_valid_i) bad++;
            if (res_valid_o && rv_cyc < 0) rv_cyc = cyc;
            if (cyc == 2) check("stall_readies", {a_ready_o, b_ready_o}, 2'b01);
            tick();
        end
        idle_inputs();
        check("stall_fire_count", 64'(fires), 64'd3);
        check("stall_no_lone_beat", 64'(bad), 64'd0);
        check("stall_result_cycle", 64'(rv_cyc), 64'd9);
`ifdef MX_MAC_CTRL_PERF_CNT_EN
        check("perf_stall_cnt", 64'(stall_cnt_o), 64'd3);
        check("perf_job_cnt", 64'(job_cnt_o), 64'd2);
`endif

        // k=0 start is ignored.
        any_act = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            start_i   = 1'b1;
            k_steps_i = 8'd0;
            a_valid_i = 1'b1;
            b_valid_i = 1'b1;
            #1;
            if (busy_o || done_o || res_valid_o || mac_clear_o) any_act++;
            tick();
        end
        idle_inputs();
        check("k0_no_activity", 64'(any_act), 64'd0);

        // k=2 with result backpressure and ignored starts.
        stable_bad = 0; done_cyc = -1;
        for (int cyc = 0; cyc < 13; cyc++) begin
            start_i     = (cyc == 0) || (cyc >= 5 && cyc <= 9);
            k_steps_i   = (cyc == 0) ? 8'd2 : 8'd5;
            prec_mode_i = (cyc == 0) ? 2'd1 : 2'd0;
            FP_mode_i   = (cyc == 0) ? 2'd2 : 2'd0;
            a_valid_i   = 1'b1;
            b_valid_i   = 1'b1;
            res_ready_i = (cyc >= 10);
            drive_mac(16'h2000, 8'h50, cyc);
            #1;
            if (cyc >= 5 && cyc <= 10) begin
                if ({res_valid_o, res_sign_o, res_exp_o, res_mant_o, prec_mode_o, FP_mode_o}
                    !== {1'b1, 1'b0, 8'h54, 16'h2004, 2'd1, 2'd2}) stable_bad++;
            end
            if (done_o && done_cyc < 0) done_cyc = cyc;
            if (cyc == 11) check("bp_done_not_busy", {done_o, busy_o}, 2'b10);
            if (cyc == 12) check("bp_start_ignored", {busy_o, mac_clear_o}, 2'b00);
            tick();
        end
        idle_inputs();
        check("bp_result_stable", 64'(stable_bad), 64'd0);
        check("bp_done_cycle", 64'(done_cyc), 64'd11);

        // Reset in the middle of a k=8 job.
        for (int cyc = 0; cyc < 5; cyc++) begin
            start_i     = (cyc == 0);
            k_steps_i   = 8'd8;
            prec_mode_i = 2'd2;
            FP_mode_i   = 2'd3;
            a_valid_i   = 1'b1;
            b_valid_i   = 1'b1;
            res_ready_i = 1'b1;
            tick();
        end
        rst_i = 1'b1;
        #1;
        check("midrst_immediate",
              {mac_clear_o, busy_o, a_ready_o, b_ready_o, mac_a_valid_o, res_valid_o, done_o},
              7'b1000000);
        tick();
        #1;
        check("midrst_after_edge",
              {mac_clear_o, busy_o, a_ready_o, b_ready_o, mac_a_valid_o, res_valid_o, done_o,
               prec_mode_o, FP_mode_o, res_sign_o, res_exp_o, res_mant_o},
              {1'b1, 6'b0, 4'b0, 25'b0});
`ifdef MX_MAC_CTRL_PERF_CNT_EN
        check("midrst_perf_clear", {stall_cnt_o, job_cnt_o}, 64'd0);
`endif
        rst_i = 1'b0;
        idle_inputs();
        tick();

        // Single-product job after the reset.
        rv_cyc = -1; rv_val = '0; done_cyc = -1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            start_i     = (cyc == 0);
            k_steps_i   = 8'd1;
            a_valid_i   = 1'b1;
            b_valid_i   = 1'b1;
            res_ready_i = 1'b1;
            drive_mac(16'h3000, 8'h60, cyc);
            #1;
            if (res_valid_o && rv_cyc < 0) begin
                rv_cyc = cyc;
                rv_val = {res_sign_o, res_exp_o, res_mant_o};
            end
            if (done_o && done_cyc < 0) done_cyc = cyc;
            tick();
        end
        idle_inputs();
        check("k1_result_cycle", 64'(rv_cyc), 64'd4);
        check("k1_result_value", 64'(rv_val), 64'({1'b1, 8'h63, 16'h3003}));
        check("k1_done_cycle", 64'(done_cyc), 64'd5);

        // Maximum job length.
        fires = 0; rv_cyc = -1; rv_cnt = 0; done_cnt = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            start_i     = (cyc == 0);
            k_steps_i   = 8'd255;
            a_valid_i   = 1'b1;
            b_valid_i   = 1'b1;
            res_ready_i = 1'b1;
            #1;
            if (mac_a_valid_o) fires++;
            if (res_valid_o) begin
                rv_cnt++;
                if (rv_cyc < 0) rv_cyc = cyc;
            end
            if (done_o) done_cnt++;
            tick();
        end
        idle_inputs();
        check("k255_fires", 64'(fires), 64'd255);
        check("k255_result_cycle", 64'(rv_cyc), 64'd258);
        check("k255_single_result", 64'(rv_cnt), 64'd1);
        check("k255_single_done", 64'(done_cnt), 64'd1);
`ifdef MX_MAC_CTRL_PERF_CNT_EN
        check("perf_after_reset", {stall_cnt_o, job_cnt_o}, {32'd0, 32'd2});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mx_mac_ctrl.md
# mx_mac_ctrl

Sequencer for one MX MAC processing element (MX_MAC_EA_BPE datapath). It accepts a job of `k_steps` reduction steps and latches precision/FP mode for the job. It clears the MAC accumulator, then gates paired A/B operand beats into the MAC through valid/ready handshakes. When the reduction is complete, it captures the accumulated FP result and presents it on a valid/ready output port. It sits between the operand streamers and the MAC, one instance per PE.

## Interface
Parameters:
- `K_W`, 8: width of the step count; max job length 2^K_W−1.
- `M_out_width`, 16: MAC mantissa width, matches the MAC.

Ports:
- Reset is synchronous and active-high (decided).
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous active-high reset.
- `start_i` in 1: job request, sampled only in IDLE.
- `k_steps_i` in K_W: number of operand beats in the job.
- `prec_mode_i` in 2: 0 = 8b, 1 = 4b, 2 = 2b.
- `FP_mode_i` in 2: element FP format.
- `busy_o` out 1: high in any state other than IDLE.
- `done_o` out 1: one-cycle pulse after result handshake.
- `a_valid_i` in 1 / `a_ready_o` out 1: A operand beat handshake.
- `b_valid_i` in 1 / `b_ready_o` out 1: B operand beat handshake.
- `mac_a_valid_o`, `mac_b_valid_o` out 1: drive the MAC A_valid/B_valid.
- `mac_clear_o` out 1: accumulator clear to MAC.
- `prec_mode_o`, `FP_mode_o` out 2: latched job mode to MAC.
- `mac_mant_i` in M_out_width, `mac_exp_i` in 8, `mac_sign_i` in 1: MAC accumulator outputs.
- `res_valid_o` out 1 / `res_ready_i` in 1: result handshake.
- `res_mant_o` out M_out_width, `res_exp_o` out 8, `res_sign_o` out 1: captured result.

## Operation
- FSM states: IDLE, CLEAR, ACCUM, DRAIN, OUT.
- IDLE:
  - `start_i` with `k_steps_i` ≠ 0: latch k_steps and both modes, go to CLEAR.
  - `start_i` with `k_steps_i` = 0: ignored; no done, no result.
- CLEAR: `mac_clear_o` = 1 for exactly one cycle, then go to ACCUM; step counter reset to 0.
- ACCUM:
  - fire = `a_valid_i & b_valid_i`; `a_ready_o` = `b_valid_i`; `b_ready_o` = `a_valid_i`.
  - A and B are never consumed separately.
  - `mac_a_valid_o` = `mac_b_valid_o` = fire.
  - Counter increments on fire.
  - fire with counter == k_steps−1: go to DRAIN.
  - Counter never exceeds k_steps−1, so no wrap.
- DRAIN: MAC register now holds the final sum; capture `mac_*_i` into `res_*` regs, go to OUT.
- OUT: `res_valid_o` = 1, data held stable until `res_ready_i`. On handshake, go to IDLE and pulse `done_o` next cycle.
- Outside ACCUM: all readies and `mac_*_valid_o` are 0.
- `start_i` while busy: ignored.
- `prec_mode_o`/`FP_mode_o` constant for the whole job, changed only on an accepted start.
- Reset (any state, mid-job included):
  - state returns to IDLE; counter, latched modes, res regs and `done_o` go to 0.
  - `mac_clear_o` = 1 while `rst_i` is high.
  - All other outputs are 0.
  - The partial accumulation is abandoned.

## Timing
- Start sampled at cycle 0: CLEAR in cycle 1, first possible fire in cycle 2.
- With back-to-back fires: last fire in cycle k+1, DRAIN in k+2, `res_valid_o` from cycle k+3.
- `done_o` is high in the cycle after the result handshake; `busy_o` is 0 in that same cycle.
- Next start is accepted in that cycle: minimum job-to-job turnaround is k+4 cycles with immediate `res_ready_i`.
- Operand stalls extend ACCUM by one cycle per non-fire cycle; no timeout.
- Readies are combinational from the opposite valid; all other outputs are registered or pure state decode.

## Configuration
- `MX_MAC_CTRL_PERF_CNT_EN` defined: adds outputs `stall_cnt_o`[31:0] and `job_cnt_o`[31:0].
  - `stall_cnt_o`: cycles in ACCUM without fire.
  - `job_cnt_o`: completed result handshakes.
  - Both saturate at 2^32−1, cleared only by `rst_i`.
- Macro undefined: those ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared package `mx_mac_pkg`:
  - FSM state enum `mac_ctrl_state_e`.
  - `prec_mode_e` (PREC_8B=0, PREC_4B=1, PREC_2B=2).
  - FP_mode encoding constants.
  - Result struct (mant/exp/sign), parameterised via M_out_width at use site.
- Sub-module `mx_mac_ctrl_perf` holds the two saturating counters; instantiated only under the macro.
- FSM, step counter and result regs stay in the top module.

## Test plan
- k=4, both streams always valid, `res_ready_i`=1:
  - fires in cycles 2–5, `mac_clear_o` only in cycle 1.
  - `res_valid_o` in cycle 7 with data equal to the MAC outputs sampled in cycle 6.
  - `done_o` in cycle 8.
- k=3, A valid every cycle, B valid only on odd cycles: no beat consumed unless both are valid; exactly 3 fires; `stall_cnt_o` equals the stall cycles (macro on).
- k=0 start: FSM stays IDLE; `busy_o`, `done_o` and `res_valid_o` remain 0.
- k=2 with `res_ready_i` low for 5 cycles: result data and valid are stable throughout; `start_i` pulses during this time are ignored.
- `rst_i` asserted mid-ACCUM of a k=8 job:
  - all outputs return to reset values and `mac_clear_o`=1 during reset.
  - a following k=1 job produces the single-product result.
- k=255 (max for K_W=8): exactly 255 fires, no counter wrap, single result.
